ray_lane_scheduler: RTL and testbench

//  N-lane successor to the single-pipeline ray path. Pops rays from the input ray FIFO (FWFT) and tags each with a sequential ray ID.

---
 rtl/ray_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 21 ++
 rtl/ray_lane_scheduler.sv | 126 ++++++++++++
 tb/tb_ray_lane_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_sched_pkg.sv
// ray_sched_pkg: shared constants, types and helpers for the ray lane scheduler.
package ray_sched_pkg;
   localparam int D_BITS  = 32;
   localparam int Q_BITS  = 10;
   localparam int M_BITS  = 12;
   localparam int ID_BITS = 12;
   typedef logic [5:0][D_BITS-1:0] ray_t;
   typedef struct packed {
      logic              hit;
      logic [M_BITS-1:0] triangle_ID;
   } result_t;
   typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;
   function automatic int unsigned rob_idx(input int unsigned id, input int unsigned depth);
      return id & (depth - 1);
   endfunction
   function automatic bit rob_depth_ok(input int unsigned depth);
      return depth >= 2 && (depth & (depth - 1)) == 0;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr, wrapping around N inputs.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = N > 1 ? $clog2(N) : 1
)(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);
   // scan from the farthest offset down so the nearest requester wins
   always_comb begin
      gnt_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[IW'((int'(ptr) + i) % N)]) gnt_idx = IW'((int'(ptr) + i) % N);
      end
   end
   assign any = |req;
   assign gnt = any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/ray_lane_scheduler.sv
// ray_lane_scheduler: round-robin ray dispatch to N_LANES lanes, in-order retire through a ROB.
// Define RAY_SCHED_STATS_EN to enable the stat_dispatched / stat_stall counters.
module ray_lane_scheduler
   import ray_sched_pkg::*;
#(
   parameter int D_BITS    = ray_sched_pkg::D_BITS,
   parameter int Q_BITS    = ray_sched_pkg::Q_BITS,
   parameter int M_BITS    = ray_sched_pkg::M_BITS,
   parameter int N_LANES   = 4,
   parameter int ROB_DEPTH = 16,
   parameter int ID_BITS   = ray_sched_pkg::ID_BITS
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_empty,
   output logic                      in_rd_en,
   input  logic [6*D_BITS-1:0]       ray_in,
   input  logic [N_LANES-1:0]        lane_full,
   output logic [N_LANES-1:0]        lane_wr_en,
   output logic [6*D_BITS-1:0]       lane_ray,
   output logic [ID_BITS-1:0]        lane_ray_id,
   input  logic [N_LANES-1:0]        res_empty,
   output logic [N_LANES-1:0]        res_rd_en,
   input  logic [N_LANES-1:0]        res_hit,
   input  logic [N_LANES*M_BITS-1:0] res_triangle_ID,
   input  logic [N_LANES*ID_BITS-1:0] res_ray_id,
   input  logic                      out_full,
   output logic                      out_wr_en,
   output logic                      out_hit,
   output logic [M_BITS-1:0]         out_triangle_ID,
   output logic [ID_BITS-1:0]        out_ray_id,
   input  logic                      flush_req,
   output logic                      flush_done,
   output logic                      err_bad_id,
   output logic [31:0]               stat_dispatched,
   output logic [31:0]               stat_stall
);
   localparam int LW = N_LANES > 1 ? $clog2(N_LANES) : 1;
   localparam int RW = $clog2(ROB_DEPTH);
   state_t               state;
   logic [ID_BITS-1:0]   next_id, head_id, c_id, c_age;
   logic [RW:0]          outstanding;
   logic [ROB_DEPTH-1:0] rob_valid;
   logic [M_BITS:0]      rob [ROB_DEPTH];
   logic [LW-1:0]        rr_disp, rr_coll, d_idx, c_idx;
   logic [N_LANES-1:0]   d_gnt;
   logic [RW-1:0]        c_slot, head;
   logic                 d_any, c_any, disp, ret, c_ok;
   function automatic logic [LW-1:0] nxt(input logic [LW-1:0] i);
      return i == LW'(N_LANES - 1) ? '0 : i + 1'b1;
   endfunction
   always_comb assert (rob_depth_ok(ROB_DEPTH) && ID_BITS > RW && Q_BITS < D_BITS && N_LANES >= 1 && N_LANES <= 8);
   rr_arbiter #(.N(N_LANES)) u_disp_arb (.req(~lane_full), .ptr(rr_disp), .gnt(d_gnt), .gnt_idx(d_idx), .any(d_any));
   rr_arbiter #(.N(N_LANES)) u_coll_arb (.req(~res_empty), .ptr(rr_coll), .gnt(res_rd_en), .gnt_idx(c_idx), .any(c_any));
   // outstanding never exceeds ROB_DEPTH, so its MSB alone means the ROB is full
   assign disp        = state == RUN && !flush_req && !in_empty && !outstanding[RW] && d_any;
   assign in_rd_en    = disp;
   assign lane_wr_en  = disp ? d_gnt : '0;
   assign lane_ray    = ray_in;
   assign lane_ray_id = next_id;
   assign c_id        = res_ray_id[c_idx*ID_BITS +: ID_BITS];
   assign c_age       = c_id - head_id;
   assign c_slot      = RW'(rob_idx(32'(c_id), ROB_DEPTH));
   assign head        = head_id[RW-1:0];
   // an ID is live only if it lies in [head_id, head_id + outstanding)
   assign c_ok        = c_any && !rob_valid[c_slot] && 32'(c_age) < 32'(outstanding);
   assign ret         = rob_valid[head] && !out_full;
   always_ff @(posedge clock)
      if (c_ok) rob[c_slot] <= {res_hit[c_idx], res_triangle_ID[c_idx*M_BITS +: M_BITS]};
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= RUN;
         next_id         <= '0;
         head_id         <= '0;
         outstanding     <= '0;
         rob_valid       <= '0;
         rr_disp         <= '0;
         rr_coll         <= '0;
         out_wr_en       <= 1'b0;
         out_hit         <= 1'b0;
         out_triangle_ID <= '0;
         out_ray_id      <= '0;
         flush_done      <= 1'b0;
         err_bad_id      <= 1'b0;
      end else begin
         if (disp) begin
            next_id <= next_id + 1'b1;
            rr_disp <= nxt(d_idx);
         end
         if (c_any) rr_coll <= nxt(c_idx);
         if (c_ok) rob_valid[c_slot] <= 1'b1;
         if (ret) rob_valid[head] <= 1'b0;
         err_bad_id  <= err_bad_id | (c_any & !c_ok);
         out_wr_en   <= ret;
         outstanding <= outstanding + (RW+1)'(disp) - (RW+1)'(ret);
         if (ret) begin
            out_hit         <= rob[head][M_BITS];
            out_triangle_ID <= rob[head][M_BITS-1:0];
            out_ray_id      <= head_id;
            head_id         <= head_id + 1'b1;
         end
         if (state == RUN && flush_req) state <= DRAIN;
         else if (state == DRAIN && outstanding == '0) begin
            state      <= IDLE;
            flush_done <= 1'b1;
         end else if (state == IDLE && !flush_req) begin
            state      <= RUN;
            flush_done <= 1'b0;
         end
      end
   end
`ifdef RAY_SCHED_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_dispatched <= '0;
         stat_stall      <= '0;
      end else begin
         if (disp && !(&stat_dispatched)) stat_dispatched <= stat_dispatched + 1'b1;
         if (!in_empty && !disp && !(&stat_stall)) stat_stall <= stat_stall + 1'b1;
      end
   end
`else
   assign stat_dispatched = '0;
   assign stat_stall      = '0;
`endif
endmodule

// File: tb/tb_ray_lane_scheduler.sv
// tb_ray_lane_scheduler: vector table, corner-case sequences and a randomized lane model.
module tb_ray_lane_scheduler;
   localparam int D = 32, M = 12, IB = 12, NL = 4, RD = 16;
   logic clock = 1'b0, reset;
   logic in_empty, in_rd_en, out_full, out_wr_en, out_hit, flush_req, flush_done, err_bad_id;
   logic [6*D-1:0]  ray_in, lane_ray;
   logic [NL-1:0]   lane_full, lane_wr_en, res_empty, res_rd_en, res_hit;
   logic [IB-1:0]   lane_ray_id, out_ray_id;
   logic [NL*M-1:0] res_triangle_ID;
   logic [NL*IB-1:0] res_ray_id;
   logic [M-1:0]    out_triangle_ID;
   logic [31:0]     stat_dispatched, stat_stall;
   int errs = 0, checks = 0;
   int outq[$];
   typedef struct packed {
      logic [3:0]  full;
      logic [3:0]  wr;
      logic [11:0] id;
   } vec_t;
   vec_t tv[10];

   always #5 clock = ~clock;

   ray_lane_scheduler #(.D_BITS(D), .M_BITS(M), .N_LANES(NL), .ROB_DEPTH(RD), .ID_BITS(IB)) dut (
      .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(in_rd_en), .ray_in(ray_in),
      .lane_full(lane_full), .lane_wr_en(lane_wr_en), .lane_ray(lane_ray), .lane_ray_id(lane_ray_id),
      .res_empty(res_empty), .res_rd_en(res_rd_en), .res_hit(res_hit), .res_triangle_ID(res_triangle_ID),
      .res_ray_id(res_ray_id), .out_full(out_full), .out_wr_en(out_wr_en), .out_hit(out_hit),
      .out_triangle_ID(out_triangle_ID), .out_ray_id(out_ray_id), .flush_req(flush_req),
      .flush_done(flush_done), .err_bad_id(err_bad_id), .stat_dispatched(stat_dispatched), .stat_stall(stat_stall));

   function automatic logic f_hit(input int id);
      return id[0] ^ id[2];
   endfunction
   function automatic logic [M-1:0] f_tri(input int id);
      return M'(id * 37 + 5);
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      in_empty = 1'b1; lane_full = '0; res_empty = '1; res_hit = '0;
      res_triangle_ID = '0; res_ray_id = '0; out_full = 1'b0; flush_req = 1'b0; ray_in = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1'b1;
      #12;
      @(negedge clock);
      reset = 1'b0;
      outq.delete();
      tick();
   endtask

   // present one result on a lane for a single cycle; the scheduler must pop it
   task automatic ret_one(input int lane, input int id);
      res_empty = '1;
      res_empty[lane] = 1'b0;
      res_hit[lane] = f_hit(id);
      res_triangle_ID[lane*M +: M] = f_tri(id);
      res_ray_id[lane*IB +: IB] = IB'(id);
      #1 chk("res_rd_en", res_rd_en, 64'(1) << lane);
      tick();
      res_empty = '1;
   endtask

   // every retired result must carry the data the lanes produced for that ID
   always @(negedge clock) if (!reset && out_wr_en) begin
      outq.push_back(int'(out_ray_id));
      chk("out_data", {out_hit, out_triangle_ID}, {f_hit(int'(out_ray_id)), f_tri(int'(out_ray_id))});
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit found;
      tv[0] = {4'b0000, 4'b0001, 12'd0};
      tv[1] = {4'b0000, 4'b0010, 12'd1};
      tv[2] = {4'b0000, 4'b0100, 12'd2};
      tv[3] = {4'b0000, 4'b1000, 12'd3};
      tv[4] = {4'b0000, 4'b0001, 12'd4};
      tv[5] = {4'b0010, 4'b0100, 12'd5};
      tv[6] = {4'b1000, 4'b0001, 12'd6};
      tv[7] = {4'b1111, 4'b0000, 12'd7};
      tv[8] = {4'b1110, 4'b0001, 12'd7};
      tv[9] = {4'b0110, 4'b1000, 12'd8};

      do_reset();
      chk("rst_out_wr_en", out_wr_en, 0);
      chk("rst_out_data", {out_hit, out_triangle_ID, out_ray_id}, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_err", err_bad_id, 0);
      chk("rst_strobes", {in_rd_en, lane_wr_en, res_rd_en}, 0);
      chk("rst_next_id", lane_ray_id, 0);
      chk("rst_stats", {stat_dispatched, stat_stall}, 0);

      in_empty = 1'b0;
      for (int i = 0; i < 10; i++) begin
         lane_full = tv[i].full;
         ray_in = {6{$urandom}};
         #1;
         chk("tv_lane_wr_en", lane_wr_en, tv[i].wr);
         chk("tv_in_rd_en", in_rd_en, |tv[i].wr);
         chk("tv_ray_id", lane_ray_id, tv[i].id);
         tick();
      end

      // out-of-order returns come out in ID order
      do_reset();
      in_empty = 1'b0;
      repeat (4) tick();
      in_empty = 1'b1;
      ret_one(3, 3); ret_one(1, 1); ret_one(0, 0); ret_one(2, 2);
      repeat (4) tick();
      chk("t2_count", outq.size(), 4);
      for (int i = 0; i < 4 && i < outq.size(); i++) chk("t2_order", outq[i], i);

      // ROB full blocks dispatch until the first retire
      do_reset();
      in_empty = 1'b0;
      n = 0;
      repeat (20) begin
         #1 n += int'(in_rd_en);
         tick();
      end
      chk("t4_dispatched", n, RD);
      chk("t4_blocked", in_rd_en, 0);
      ret_one(0, 0);
      for (int i = 0; i < 6 && !in_rd_en; i++) tick();
      chk("t4_reopen", in_rd_en, 1);
      in_empty = 1'b1;

      // out_full stalls retire only
      do_reset();
      in_empty = 1'b0;
      repeat (2) tick();
      in_empty = 1'b1;
      out_full = 1'b1;
      ret_one(1, 1); ret_one(0, 0);
      repeat (5) begin
         chk("t5_stall", out_wr_en, 0);
         tick();
      end
      out_full = 1'b0;
      repeat (4) tick();
      chk("t5_count", outq.size(), 2);
      for (int i = 0; i < 2 && i < outq.size(); i++) chk("t5_order", outq[i], i);

      // flush with 3 outstanding, then a duplicate return
      do_reset();
      in_empty = 1'b0;
      repeat (3) tick();
      flush_req = 1'b1;
      #1 chk("t6_no_disp_now", in_rd_en, 0);
      n = 0;
      ret_one(0, 0); n += int'(in_rd_en);
      ret_one(1, 1); n += int'(in_rd_en);
      ret_one(2, 2); n += int'(in_rd_en);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (out_wr_en && out_ray_id == 12'd2) found = 1'b1;
         else tick();
         n += int'(in_rd_en);
      end
      chk("t6_third_retire", found, 1);
      chk("t6_done_pre", flush_done, 0);
      tick();
      chk("t6_done", flush_done, 1);
      chk("t6_no_dispatch", n, 0);
      chk("t6_err_clear", err_bad_id, 0);
      ret_one(1, 1);
      repeat (3) tick();
      chk("t6_err_dup", err_bad_id, 1);
      chk("t6_no_extra", outq.size(), 3);
      flush_req = 1'b0;
      tick();
      chk("t6_resume", in_rd_en, 1);
      chk("t6_done_clear", flush_done, 0);
      in_empty = 1'b1;

      // randomized traffic against a queue-based lane and ordering model
      do_reset();
      begin : rnd
         int inq[NL][$];
         int resq[NL][$];
         int rr_d, rr_c, nid, outst, exp_ret, el, ec, idx;
         rr_d = 0; rr_c = 0; nid = 0; outst = 0; exp_ret = 0;
         for (int cyc = 0; cyc < 1700; cyc++) begin
            in_empty = !(cyc < 1500 && $urandom_range(0, 3) != 0);
            out_full = $urandom_range(0, 4) == 0;
            ray_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            for (int l = 0; l < NL; l++) begin
               lane_full[l] = inq[l].size() >= 2 || $urandom_range(0, 7) == 0;
               res_empty[l] = resq[l].size() == 0;
               if (resq[l].size() != 0) begin
                  res_ray_id[l*IB +: IB] = IB'(resq[l][0]);
                  res_hit[l] = f_hit(resq[l][0]);
                  res_triangle_ID[l*M +: M] = f_tri(resq[l][0]);
               end
            end
            #1;
            el = -1;
            if (!in_empty && outst < RD)
               for (int k = 0; k < NL; k++) begin
                  idx = (rr_d + k) % NL;
                  if (el < 0 && !lane_full[idx]) el = idx;
               end
            ec = -1;
            for (int k = 0; k < NL; k++) begin
               idx = (rr_c + k) % NL;
               if (ec < 0 && resq[idx].size() != 0) ec = idx;
            end
            chk("rnd_lane_wr_en", lane_wr_en, el < 0 ? 0 : 64'(1) << el);
            if (el >= 0) begin
               chk("rnd_ray_id", lane_ray_id, IB'(nid));
               chk("rnd_ray_bcast", lane_ray == ray_in, 1);
            end
            chk("rnd_res_rd_en", res_rd_en, ec < 0 ? 0 : 64'(1) << ec);
            tick();
            if (el >= 0) begin
               inq[el].push_back(nid);
               nid++;
               outst++;
               rr_d = (el + 1) % NL;
            end
            if (ec >= 0) begin
               void'(resq[ec].pop_front());
               rr_c = (ec + 1) % NL;
            end
            if (out_wr_en) outst--;
            for (int l = 0; l < NL; l++)
               if (inq[l].size() != 0 && $urandom_range(0, 1) == 1) resq[l].push_back(inq[l].pop_front());
            while (outq.size() != 0) begin
               chk("rnd_order", outq.pop_front(), exp_ret);
               exp_ret++;
            end
         end
         chk("rnd_drained", outst, 0);
         chk("rnd_all_retired", exp_ret, nid);
         chk("rnd_no_err", err_bad_id, 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
